// File: rtl/pc_sequencer_pkg.sv
// Shared types and the branch/call target helper for the fetch-stage PC sequencer.
// PC_REL_BRANCH_EN selects PC-relative targets (two's-complement offset) instead of absolute.
package pc_pkg;

    localparam int PC_MAX_W = 32;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_HOLD,
        PC_BRANCH,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Callers pass zero-extended AW-bit values and truncate the result to AW bits.
    function automatic logic [PC_MAX_W-1:0] next_target(
        input logic [PC_MAX_W-1:0] pc,
        input logic [PC_MAX_W-1:0] tgt,
        input int                  aw
    );
`ifdef PC_REL_BRANCH_EN
        logic [PC_MAX_W-1:0] sx;
        sx = $unsigned($signed(tgt << (PC_MAX_W - aw)) >>> (PC_MAX_W - aw));
        return pc + sx;
`else
        return tgt | (pc & '0);
`endif
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/branch-logic <-> PC sequencer bundle: control inputs and the registered fetch state.
interface pc_sequencer_if #(
    parameter int AW = 9,
    parameter int LW = 3
);
    logic [AW-1:0] start_addr;
    logic          stall;
    logic          ctrl_branch;
    logic          take_branch;
    logic          ctrl_call;
    logic          ctrl_ret;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] pc;
    logic          halt;
    logic          stack_err;
    logic [LW-1:0] stack_level;

    modport master (
        output start_addr, stall, ctrl_branch, take_branch, ctrl_call, ctrl_ret, branch_target,
        input  pc, halt, stack_err, stack_level
    );

    modport slave (
        input  start_addr, stall, ctrl_branch, take_branch, ctrl_call, ctrl_ret, branch_target,
        output pc, halt, stack_err, stack_level
    );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack (LIFO) for call/ret. Overflowing pushes and underflowing pops are ignored;
// the caller is expected to check full/empty and flag the error itself.
module ret_stack #(
    parameter int AW          = 9,
    parameter int STACK_DEPTH = 4,
    parameter int LW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AW-1:0] mem_q [STACK_DEPTH];
    logic [AW-1:0] mem_d [STACK_DEPTH];
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] lvl_m1;

    assign full   = (level_q == LW'(STACK_DEPTH));
    assign empty  = (level_q == '0);
    assign level  = level_q;
    assign lvl_m1 = level_q - LW'(1);
    assign top    = mem_q[lvl_m1[IW-1:0]];

    always_comb begin
        mem_d   = mem_q;
        level_d = level_q;
        if (push && !full) begin
            mem_d[level_q[IW-1:0]] = din;
            level_d                = level_q + LW'(1);
        end else if (pop && !empty) begin
            level_d = lvl_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) level_q <= '0;
        else       level_q <= level_d;
    end

    // Contents are meaningless once level is cleared, so they carry no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential/branch/call/ret with a return-address stack,
// sticky halt at HALT_ADDR and sticky stack error. PC_REL_BRANCH_EN makes targets PC-relative.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int AW          = 9,
    parameter int HALT_ADDR   = 31,
    parameter int STACK_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int            LW     = $clog2(STACK_DEPTH + 1);
    localparam logic [AW-1:0] HALT_V = AW'(HALT_ADDR);

    logic [AW-1:0] pc_q, pc_d;
    logic          halt_q, halt_d;
    logic          err_q, err_d;
    logic          active;
    pc_op_e        op;
    logic [AW-1:0] target;
    logic          push, pop;
    logic [AW-1:0] top;
    logic          full, empty;
    logic [LW-1:0] level;

    assign active = !bus.stall && !halt_q;
    assign target = AW'(next_target(PC_MAX_W'(pc_q), PC_MAX_W'(bus.branch_target), AW));

    always_comb begin
        if (bus.ctrl_ret)                            op = PC_RET;
        else if (bus.ctrl_call)                      op = PC_CALL;
        else if (bus.ctrl_branch && bus.take_branch) op = PC_BRANCH;
        else if (bus.ctrl_branch)                    op = PC_HOLD;
        else                                         op = PC_SEQ;
    end

    always_comb begin
        pc_d   = pc_q;
        halt_d = halt_q;
        err_d  = err_q;
        push   = 1'b0;
        pop    = 1'b0;
        if (active) begin
            unique case (op)
                PC_RET: begin
                    if (!empty) begin
                        pc_d = top;
                        pop  = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        halt_d = 1'b1;
                    end
                end
                PC_CALL: begin
                    if (!full) begin
                        pc_d = target;
                        push = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        halt_d = 1'b1;
                    end
                end
                PC_BRANCH: pc_d = target;
                PC_HOLD:   pc_d = pc_q;
                PC_SEQ:    pc_d = pc_q + AW'(1);
                default:   pc_d = pc_q;
            endcase
            // The halting instruction still retires its pc update; halt freezes the next one.
            if (pc_q >= HALT_V) halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= bus.start_addr;
            halt_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_d;
            err_q  <= err_d;
        end
    end

    ret_stack #(
        .AW          (AW),
        .STACK_DEPTH (STACK_DEPTH),
        .LW          (LW)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_q + AW'(1)),
        .top   (top),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign bus.pc          = pc_q;
    assign bus.halt        = halt_q;
    assign bus.stack_err   = err_q;
    assign bus.stack_level = level;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed literal checks plus randomized traffic against a queue-based model.
module tb_pc_sequencer;
    localparam int AW = 9, HALT_ADDR = 31, DEPTH = 4, LW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.AW(AW), .LW(LW)) bus();

    pc_sequencer #(.AW(AW), .HALT_ADDR(HALT_ADDR), .STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    int m_pc;
    bit m_halt, m_err;
    int m_stk[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tgt_of(input int pc, input int bt);
`ifdef PC_REL_BRANCH_EN
        int off;
        off = (bt >= 256) ? bt - 512 : bt;
        return (pc + off + 512) % 512;
`else
        return bt + 0 * pc;
`endif
    endfunction

    task automatic model_step();
        bit h;
        int t;
        if (reset) begin
            m_pc   = int'(bus.start_addr);
            m_halt = 1'b0;
            m_err  = 1'b0;
            m_stk.delete();
        end else if (!bus.stall && !m_halt) begin
            h = (m_pc >= HALT_ADDR);
            t = tgt_of(m_pc, int'(bus.branch_target));
            if (bus.ctrl_ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_err = 1'b1; h = 1'b1; end
            end else if (bus.ctrl_call) begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back((m_pc + 1) % 512);
                    m_pc = t;
                end else begin m_err = 1'b1; h = 1'b1; end
            end else if (bus.ctrl_branch && bus.take_branch) m_pc = t;
            else if (!bus.ctrl_branch) m_pc = (m_pc + 1) % 512;
            m_halt = m_halt | h;
        end
    endtask

    task automatic cyc(input bit r, input bit st, input bit br, input bit tk, input bit cl,
                       input bit rt, input int tgt, input int sa);
        reset             = r;
        bus.stall         = st;
        bus.ctrl_branch   = br;
        bus.take_branch   = tk;
        bus.ctrl_call     = cl;
        bus.ctrl_ret      = rt;
        bus.branch_target = AW'(tgt);
        bus.start_addr    = AW'(sa);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rst(input int sa);
        cyc(1, 0, 0, 0, 0, 0, 0, sa);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pc",    bus.pc,          m_pc);
            chk("model_halt",  bus.halt,        m_halt);
            chk("model_err",   bus.stack_err,   m_err);
            chk("model_level", bus.stack_level, m_stk.size());
        end
    end

    initial begin
        bit r, st, br, tk, cl, rt;
        int tgt, sa;

        rst(5);
        chk_en = 1'b1;
        chk("reset_pc", bus.pc, 5);
        chk("reset_halt", bus.halt, 0);
        chk("reset_err", bus.stack_err, 0);
        chk("reset_level", bus.stack_level, 0);
        idle(); chk("seq_pc6", bus.pc, 6);
        idle(); chk("seq_pc7", bus.pc, 7);
        idle(); chk("seq_pc8", bus.pc, 8);

`ifndef PC_REL_BRANCH_EN
        rst(12);
        cyc(0, 1, 0, 0, 0, 0, 0, 0); chk("stall1_pc", bus.pc, 12);
        cyc(0, 1, 1, 1, 0, 0, 20, 0); chk("stall2_pc", bus.pc, 12);
        cyc(0, 0, 1, 1, 0, 0, 20, 0); chk("br_taken_pc", bus.pc, 20);
        cyc(0, 0, 1, 0, 0, 0, 25, 0); chk("br_bubble_pc", bus.pc, 20);

        rst(3);
        cyc(0, 0, 0, 0, 1, 0, 40, 0); chk("call_pc", bus.pc, 40); chk("call_level", bus.stack_level, 1);
        // pc 40 is past HALT_ADDR, so ret still executes but halts afterwards
        cyc(0, 0, 0, 0, 0, 1, 0, 0); chk("ret_pc", bus.pc, 4); chk("ret_level", bus.stack_level, 0);
        rst(7);
        cyc(0, 0, 0, 0, 1, 1, 20, 0);
        chk("callret_pc", bus.pc, 7); chk("callret_err", bus.stack_err, 1);
        chk("callret_halt", bus.halt, 1); chk("callret_level", bus.stack_level, 0);

        rst(0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 10 + 2 * i, 0);
            chk("nest_level", bus.stack_level, i + 1);
        end
        cyc(0, 0, 0, 0, 1, 0, 25, 0);
        chk("ovf_pc", bus.pc, 16); chk("ovf_err", bus.stack_err, 1);
        chk("ovf_halt", bus.halt, 1); chk("ovf_level", bus.stack_level, 4);
        rst(2);
        chk("rst_after_pc", bus.pc, 2); chk("rst_after_err", bus.stack_err, 0);
        chk("rst_after_halt", bus.halt, 0); chk("rst_after_level", bus.stack_level, 0);

        rst(29);
        idle(); chk("hseq_pc30", bus.pc, 30); chk("hseq_halt30", bus.halt, 0);
        idle(); chk("hseq_pc31", bus.pc, 31); chk("hseq_halt31", bus.halt, 0);
        idle(); chk("hseq_pc32", bus.pc, 32); chk("hseq_halt32", bus.halt, 1);
        cyc(0, 0, 1, 1, 0, 0, 5, 0); chk("frozen_pc", bus.pc, 32);
`else
        rst(10);
        cyc(0, 0, 1, 1, 0, 0, 9'h1FE, 0); chk("rel_back_pc", bus.pc, 8);
        rst(9'h1FF);
        cyc(0, 0, 1, 1, 0, 0, 2, 0); chk("rel_wrap_pc", bus.pc, 1); chk("rel_wrap_halt", bus.halt, 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 31) == 0) || (m_halt && $urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 3) == 0);
            tk  = $urandom_range(0, 1);
            cl  = ($urandom_range(0, 5) == 0);
            rt  = ($urandom_range(0, 5) == 0);
`ifdef PC_REL_BRANCH_EN
            tgt = ($urandom_range(0, 16) + 512 - 8) % 512;
`else
            tgt = $urandom_range(0, 40);
`endif
            sa  = $urandom_range(0, 24);
            cyc(r, st, br, tk, cl, rt, tgt, sa);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the fetch stage. Generalises the single-register next-PC block.
- Adds configurable address width, a stall input, call/return via an internal return-address stack, sticky halt and a stack-error flag.
- Feeds the instruction-memory address; control inputs come from the decode/branch logic.

Parameters:
- AW, 9, PC/address width in bits
- HALT_ADDR, 31, halt is raised when an active cycle sees pc >= HALT_ADDR (unsigned)
- STACK_DEPTH, 4, return-address stack entries (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_addr  in  AW  PC loaded on reset
- stall  in  1  hold all state this cycle
- ctrl_branch  in  1  current instruction is a conditional branch
- take_branch  in  1  branch condition true; qualified by ctrl_branch
- ctrl_call  in  1  unconditional call to the target
- ctrl_ret  in  1  return to the top-of-stack address
- branch_target  in  AW  absolute target, or signed offset under PC_REL_BRANCH_EN
- pc  out  AW  current instruction address (registered)
- halt  out  1  sticky halted flag
- stack_err  out  1  sticky stack overflow/underflow flag
- stack_level  out  $clog2(STACK_DEPTH+1)  current stack occupancy

Behaviour:
- Reset (clk edge with reset=1): pc<=start_addr, halt<=0, stack_err<=0, stack_level<=0. Stack contents are don't-care. Reset overrides all other inputs, including mid-stall and while halted.
- Cycle types:
  - Active cycle: !reset && !stall && !halt.
  - Stalled or halted cycle: every register holds.
- Active-cycle priority: ctrl_ret > ctrl_call > (ctrl_branch && take_branch) > sequential.
  - ret, stack not empty: pc<=top, pop.
  - ret, stack empty: pc holds, stack_err<=1, halt<=1.
  - call, stack not full: push (pc+1) mod 2^AW, then pc<=target.
  - call, stack full: pc holds, no push, stack_err<=1, halt<=1.
  - branch taken: pc<=target.
  - ctrl_branch && !take_branch: pc holds. This is an intentional bubble and matches existing branch semantics.
  - none asserted: pc<=(pc+1) mod 2^AW. AW'h1FF+1 wraps to 0.
- Target (default): target = branch_target.
- Halt check: on an active cycle, if the current (pre-update) pc >= HALT_ADDR, halt<=1 in the same cycle the pc update occurs.
  - halt is visible on the next cycle, so the pc after the halting instruction has already been written once.
  - From then on pc is frozen until reset.
- Simultaneous call+ret: ret wins; call is ignored; no push.
- Latency: pc changes one clk after an active cycle. No combinational paths from inputs to outputs.
- Arithmetic: all pc arithmetic is unsigned, AW bits, modulo 2^AW.

Optional Feature:
- Macro: PC_REL_BRANCH_EN.
- Defined: target = (pc + sign-extended branch_target) mod 2^AW for both branch and call. branch_target is two's-complement. Example: AW=9, pc=10, branch_target=9'h1FE gives target 8.
- Undefined: target = branch_target (absolute).

Decomposition:
- Package pc_pkg:
  - typedef enum pc_op_e {PC_SEQ, PC_HOLD, PC_BRANCH, PC_CALL, PC_RET}
  - function next_target(pc, tgt) honouring the macro
- Sub-module ret_stack:
  - Parametrised by AW and STACK_DEPTH.
  - Ports: push, pop, din, top, full, empty, level. Synchronous reset.
  - pc_sequencer decodes pc_op_e and drives ret_stack.

Test Plan (AW=9, HALT_ADDR=31, STACK_DEPTH=4, absolute mode unless noted):
- reset with start_addr=5, then 3 idle cycles -> pc 5,6,7,8; halt=0; stack_level=0.
- pc=12, stall=1 for 2 cycles, then ctrl_branch=1 take_branch=1 target=20 -> pc holds 12 for 2 cycles, then 20. ctrl_branch=1 take_branch=0 -> pc holds.
- pc=3, call target=40 -> pc=40, level=1; next cycle ret -> pc=4, level=0. Call+ret asserted together at pc=7 with empty stack -> stack_err=1, halt=1, pc=7.
- 4 nested calls then a 5th call -> levels 1..4, 5th sets stack_err=1 and halt=1, level stays 4, pc unchanged. Then reset -> pc=start_addr, flags cleared.
- start_addr=29, run sequentially -> pc 29,30,31,32; halt=1 from the cycle pc reads 32; pc frozen at 32 with branch inputs ignored.
- PC_REL_BRANCH_EN: pc=10, branch target=9'h1FE -> pc=8. pc=9'h1FF, offset=2 -> pc=1 (wrap).
